// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and small word helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Default fetch start address after reset.
    localparam lc3b_word lc3b_pc_reset = 16'h0000;

    // Next sequential instruction address; wraps 0xFFFE -> 0x0000.
    function automatic lc3b_word word_inc2(input lc3b_word a);
        return a + 16'd2;
    endfunction

    // Instructions are word aligned, so bit 0 of any fetch address is forced low.
    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline boundary register for {instruction, pc, valid} with load/hold/clear.
// Latency: 1 cycle from load to outputs.
// Backpressure: holds contents whenever neither load nor clear is asserted.
//
// Ports:
//   clk, reset                    clock, async active-high reset (all fields to 0)
//   load                          capture instruction_d/pc_d/valid_d
//   clear                         squash: drop valid, keep the stale payload
//   instruction_d, pc_d, valid_d  next contents
//   instruction, pc_out, valid    registered contents
module ifid_reg
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  logic     clear,
    input  lc3b_word instruction_d,
    input  lc3b_word pc_d,
    input  logic     valid_d,
    output lc3b_word instruction,
    output lc3b_word pc_out,
    output logic     valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= '0;
            pc_out      <= '0;
            valid       <= 1'b0;
        end else if (clear) begin
            // Only valid matters to the consumer; leaving the payload alone
            // avoids toggling 32 flops on every bubble.
            valid <= 1'b0;
        end else if (load) begin
            instruction <= instruction_d;
            pc_out      <= pc_d;
            valid       <= valid_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch: owns the PC, reads the I-cache, feeds the IF/ID register.
// Latency: 1 edge from imem_resp to IF/ID valid; one instruction per cycle with a zero-wait cache.
// Backpressure: stall freezes IF/ID; a word returned under stall is parked in hold_buf (no new read).
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   stall                      decode cannot accept; IF/ID holds
//   redirect, redirect_pc      downstream control-flow change and its target
//   imem_read, imem_address    read request / even byte address (stable until imem_resp)
//   imem_rdata, imem_resp      read data and one-cycle completion strobe
//   instruction, pc_out, valid IF/ID register (pc_out is PC+2 of the instruction)
module fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word PC_RESET = lc3b_pc_reset
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output logic     imem_read,
    output lc3b_word imem_address,
    input  lc3b_word imem_rdata,
    input  logic     imem_resp,
    output lc3b_word instruction,
    output lc3b_word pc_out,
    output logic     valid
);

    // FETCH:   a read to pc is in flight (or being issued) every cycle.
    // HOLD:    the word for pc is parked in hold_buf waiting for decode; no read.
    // DISCARD: a read to a stale address is in flight; its data will be dropped.
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t state, state_nxt;

    lc3b_word pc, pc_nxt;
    lc3b_word pending_pc, pending_nxt;
    lc3b_word hold_buf, hold_nxt;

    lc3b_word target;
    lc3b_word pc_inc;

    logic     ifid_load;
    logic     ifid_clear;
    lc3b_word ifid_instr_d;

    assign target = word_align(redirect_pc);
    assign pc_inc = word_inc2(pc);

    // The address is simply pc; pc only moves on a consumed response or in
    // HOLD (no read outstanding), so it is stable for the life of a request.
    assign imem_read    = !reset && (state != HOLD);
    assign imem_address = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= word_align(PC_RESET);
            pending_pc <= '0;
            hold_buf   <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_nxt;
            hold_buf   <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pending_nxt  = pending_pc;
        hold_nxt     = hold_buf;
        ifid_load    = 1'b0;
        ifid_clear   = 1'b0;
        ifid_instr_d = imem_rdata;

        unique case (state)
            FETCH: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                    if (imem_resp) begin
                        // Read just completed: redirect can take effect at once.
                        pc_nxt = target;
                    end else begin
                        // Read still in flight at the old pc: remember the
                        // target and wait out the stale response.
                        pending_nxt = target;
                        state_nxt   = DISCARD;
                    end
                end else if (imem_resp) begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        pc_nxt    = pc_inc;
                    end else begin
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else if (!stall) begin
                    // Wait state with decode draining: insert a bubble.
                    ifid_clear = 1'b1;
                end
            end

            HOLD: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                    pc_nxt     = target;
                    state_nxt  = FETCH;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_instr_d = hold_buf;
                    pc_nxt       = pc_inc;
                    state_nxt    = FETCH;
                end
            end

            DISCARD: begin
                // IF/ID was already invalidated by the redirect that got us
                // here, so it only needs touching on a further redirect.
                if (redirect) begin
                    ifid_clear  = 1'b1;
                    pending_nxt = target;
                end
                if (imem_resp) begin
                    pc_nxt    = redirect ? target : pending_pc;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (ifid_load),
        .clear         (ifid_clear),
        .instruction_d (ifid_instr_d),
        .pc_d          (pc_inc),
        .valid_d       (1'b1),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .valid         (valid)
    );

endmodule
